// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: single-issue read -> execute -> write-back sequencer for a 2**ADDR_W x DATA_W register file.
// Optional build macro REGFILE_ZERO_REG_EN: register 0 reads as zero and writes to it are suppressed.
module regfile_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              mode,
    output logic [ADDR_W-1:0] ReadAddress1,
    output logic [ADDR_W-1:0] ReadAddress2,
    input  logic [DATA_W-1:0] ReadValue1,
    input  logic [DATA_W-1:0] ReadValue2,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [DATA_W-1:0] WriteValue,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MOV = 2'b10, OP_LDI = 2'b11} op_t;

    localparam logic [DATA_W:0] ONE = (DATA_W + 1)'(1);

    state_t              state_q;
    op_t                 op_q;
    logic [ADDR_W-1:0]   rd_q, raddr1_q, raddr2_q, waddr_q;
    logic [DATA_W-1:0]   imm_q, opa_q, opb_q, wval_q, result_q;
    logic                mode_q, done_q, carry_q;

    logic [DATA_W:0]     exec_d;
    logic [DATA_W-1:0]   opa_d, opb_d;
    logic                we_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        exec_d = '0;
        case (op_q)
            OP_ADD:  exec_d = {1'b0, opa_q} + {1'b0, opb_q};
            OP_SUB:  exec_d = {1'b0, opa_q} + {1'b0, ~opb_q} + ONE;
            OP_MOV:  exec_d = {1'b0, opa_q};
            default: exec_d = {1'b0, imm_q};
        endcase
    end

    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        opa_d = (raddr1_q == '0) ? '0 : ReadValue1;
        opb_d = (raddr2_q == '0) ? '0 : ReadValue2;
        we_d  = (rd_q != '0);
`else
        opa_d = ReadValue1;
        opb_d = ReadValue2;
        we_d  = 1'b1;
`endif
    end

    // Bus outputs are registered one state early so they are stable for the whole READ/WRITE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            imm_q    <= '0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            waddr_q  <= '0;
            wval_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= op_t'(cmd_op);
                        raddr1_q <= cmd_rs1;
                        raddr2_q <= cmd_rs2;
                        rd_q     <= cmd_rd;
                        imm_q    <= cmd_imm;
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    opa_q   <= opa_d;
                    opb_q   <= opb_d;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    waddr_q  <= rd_q;
                    wval_q   <= exec_d[DATA_W-1:0];
                    result_q <= exec_d[DATA_W-1:0];
                    carry_q  <= exec_d[DATA_W];
                    mode_q   <= we_d;
                    done_q   <= 1'b1;
                    state_q  <= S_WRITE;
                end
                default: begin
                    mode_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (state_q == S_IDLE) && rst_n;
    assign mode         = mode_q;
    assign ReadAddress1 = raddr1_q;
    assign ReadAddress2 = raddr2_q;
    assign WriteAddress = waddr_q;
    assign WriteValue   = wval_q;
    assign done         = done_q;
    assign result       = result_q;
    assign carry        = carry_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb_regfile_op_sequencer: directed stimulus against a bench register file, with a per-cycle transaction model.
// Build with REGFILE_ZERO_REG_EN defined to exercise the zero-register variant.
module tb_regfile_op_sequencer;

    localparam int DW = 16;
    localparam int AW = 5;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic          mode, done, carry;
    logic [AW-1:0] ReadAddress1, ReadAddress2, WriteAddress;
    logic [DW-1:0] ReadValue1, ReadValue2, WriteValue, result;

    regfile_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .mode(mode), .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
        .ReadValue1(ReadValue1), .ReadValue2(ReadValue2),
        .WriteAddress(WriteAddress), .WriteValue(WriteValue),
        .done(done), .result(result), .carry(carry)
    );

    always #5 clk = ~clk;

    // Bench register file; entry 0 preloaded so zero-register forcing is visible.
    logic [DW-1:0] rf [32] = '{0: 16'h5555, default: 16'h0000};
    int            wr_cnt = 0;
    assign ReadValue1 = rf[ReadAddress1];
    assign ReadValue2 = rf[ReadAddress2];
    always @(posedge clk) begin
        if (mode) begin
            rf[WriteAddress] <= WriteValue;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Handshake capture at the accepting edge.
    logic          hs;
    logic [1:0]    hs_op;
    logic [AW-1:0] hs_rs1, hs_rs2, hs_rd;
    logic [DW-1:0] hs_imm;
    int            hs_cnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs <= 1'b0;
        else        hs <= cmd_valid && cmd_ready;
    end
    always @(posedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            hs_op  <= cmd_op;
            hs_rs1 <= cmd_rs1;
            hs_rs2 <= cmd_rs2;
            hs_rd  <= cmd_rd;
            hs_imm <= cmd_imm;
            hs_cnt <= hs_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Transaction model: architectural register contents plus position in the 4-cycle command window.
    logic [DW-1:0] model_rf [32];
    int            ph = 0;
    logic [DW-1:0] p_val, exp_res = '0;
    logic          p_c, p_we, exp_c = 1'b0;
    logic [AW-1:0] p_rd, p_rs1, p_rs2;

    function automatic logic [DW-1:0] opnd(input logic [AW-1:0] a);
        return (ZERO_EN && a == '0) ? '0 : model_rf[a];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = (i == 0) ? 16'h5555 : 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0;
                exp_res = '0;
                exp_c = 1'b0;
                check("rst_mode", mode, 0);
                check("rst_done", done, 0);
            end else begin
                if (hs) begin
                    int unsigned a, b, s;
                    ph = 1;
                    a = opnd(hs_rs1);
                    b = opnd(hs_rs2);
                    p_rs1 = hs_rs1;
                    p_rs2 = hs_rs2;
                    p_rd = hs_rd;
                    p_we = !(ZERO_EN && hs_rd == '0);
                    case (hs_op)
                        2'b00: begin s = a + b; p_val = s[15:0]; p_c = s[16]; end
                        2'b01: begin p_val = 16'(a - b); p_c = (a >= b); end
                        2'b10: begin p_val = a[15:0]; p_c = 1'b0; end
                        default: begin p_val = hs_imm; p_c = 1'b0; end
                    endcase
                end else if (ph == 3) ph = 0;
                else if (ph != 0) ph++;
                if (ph == 3) begin
                    exp_res = p_val;
                    exp_c = p_c;
                end
                check("cmd_ready", cmd_ready, ph == 0);
                check("mode", mode, ph == 3 && p_we);
                check("done", done, ph == 3);
                check("result", result, exp_res);
                check("carry", carry, exp_c);
                if (ph == 1) begin
                    check("raddr1", ReadAddress1, p_rs1);
                    check("raddr2", ReadAddress2, p_rs2);
                end
                if (ph == 3 && p_we) begin
                    check("waddr", WriteAddress, p_rd);
                    check("wvalue", WriteValue, p_val);
                    model_rf[p_rd] = p_val;
                end
            end
        end
    end

    task automatic present(input logic [1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [AW-1:0] rd, input logic [DW-1:0] imm);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rs1 = rs1;
        cmd_rs2 = rs2;
        cmd_rd = rd;
        cmd_imm = imm;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", n < 20, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [DW-1:0] imm);
        present(op, rs1, rs2, rd, imm);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int h0, w0;
        #12;
        check("lit_rst_mode", mode, 0);
        check("lit_rst_result", result, 0);
        check("lit_rst_waddr", WriteAddress, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("lit_ready_after_rst", cmd_ready, 1);

        w0 = wr_cnt;
        issue(2'b11, 0, 0, 0, 16'h1232);
        issue(2'b11, 0, 0, 1, 16'h1263);
        check("lit_ldi_result", result, 16'h1263);
        check("lit_ldi_writes", wr_cnt - w0, ZERO_EN ? 1 : 2);

        issue(2'b00, 0, 1, 2, 16'h0);
        check("lit_add_r2", rf[2], ZERO_EN ? 16'h1263 : 16'h2495);
        check("lit_add_carry", carry, 0);

        issue(2'b11, 0, 0, 3, 16'hFFFF);
        issue(2'b11, 0, 0, 4, 16'h0001);
        issue(2'b00, 3, 4, 5, 16'h0);
        check("lit_add_wrap", result, 16'h0000);
        check("lit_add_cy", carry, 1);
        issue(2'b01, 4, 3, 6, 16'h0);
        check("lit_sub_small", result, 16'h0002);
        check("lit_sub_borrow", carry, 0);
        issue(2'b01, 3, 4, 7, 16'h0);
        check("lit_sub_big", result, 16'hFFFE);
        check("lit_sub_noborrow", carry, 1);

        // Back-pressure: valid held for 10 cycles accepts at cycles 0, 4, 8.
        h0 = hs_cnt;
        w0 = wr_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_rs1 = 1;
        cmd_rs2 = 0;
        cmd_rd = 8;
        repeat (10) @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("lit_bp_accepts", hs_cnt - h0, 3);
        check("lit_bp_writes", wr_cnt - w0, 3);
        check("lit_bp_r8", rf[8], 16'h1263);

        // Reset while a SUB is in EXEC: nothing written, flags cleared.
        w0 = wr_cnt;
        present(2'b01, 1, 4, 10, 16'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("lit_midrst_mode", mode, 0);
        check("lit_midrst_done", done, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("lit_midrst_ready", cmd_ready, 1);
        check("lit_midrst_result", result, 0);
        check("lit_midrst_carry", carry, 0);
        check("lit_midrst_r10", rf[10], 16'h0000);
        check("lit_midrst_nowrite", wr_cnt - w0, 0);

        // Reset during WRITE drops mode before the commit edge.
        present(2'b11, 0, 0, 11, 16'h7777);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("lit_wrrst_mode", mode, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("lit_wrrst_r11", rf[11], 16'h0000);
        check("lit_wrrst_nowrite", wr_cnt - w0, 0);

        issue(2'b11, 0, 0, 0, 16'hABCD);
        check("lit_r0_result", result, 16'hABCD);
        check("lit_r0_reg", rf[0], ZERO_EN ? 16'h5555 : 16'hABCD);
        issue(2'b00, 0, 1, 9, 16'h0);
        check("lit_r9", rf[9], ZERO_EN ? 16'h1263 : 16'hBE30);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Single-issue command sequencer for the 16-bit x 32-entry register file: accepts one register-register or immediate operation per handshake.
- Sequences each operation as read operands -> execute (add/sub/move/load-immediate) -> write back, driving the register file's mode, address and write-data pins.
- Sits between an instruction source (testbench or future decode stage) and the register file; owns the file's read-address, write-address, write-value and mode inputs exclusively.

Parameters:
- DATA_W, 16, register and datapath width
- ADDR_W, 5, register address width (2**ADDR_W entries)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
- cmd_op  input  2  00 ADD, 01 SUB, 10 MOV, 11 LDI
- cmd_rs1  input  ADDR_W  source register 1
- cmd_rs2  input  ADDR_W  source register 2
- cmd_rd  input  ADDR_W  destination register
- cmd_imm  input  DATA_W  immediate for LDI
- mode  output  1  register file mode: 0 read, 1 write
- ReadAddress1  output  ADDR_W  register file read port 1 address
- ReadAddress2  output  ADDR_W  register file read port 2 address
- ReadValue1  input  DATA_W  register file read port 1 data (combinational)
- ReadValue2  input  DATA_W  register file read port 2 data (combinational)
- WriteAddress  output  ADDR_W  register file write address
- WriteValue  output  DATA_W  register file write data
- done  output  1  one-cycle pulse, write-back cycle of each command
- result  output  DATA_W  last written value, held until the next write-back
- carry  output  1  carry flag of last command, held until the next write-back

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; mode=0, done=0, result=0, carry=0, ReadAddress1/2=0, WriteAddress=0, WriteValue=0. cmd_ready=1 once rst_n deasserts.
- FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, rs1, rs2, rd and imm; go to READ.
  - Otherwise stay in IDLE; cmd_* inputs are ignored.
- READ:
  - Drive ReadAddress1=rs1 and ReadAddress2=rs2 with mode=0.
  - Capture ReadValue1/2 into operand registers at the closing edge.
- EXEC:
  - Compute a (DATA_W+1)-bit result into a result register.
  - ADD: rs1+rs2; carry = bit DATA_W.
  - SUB: rs1 + ~rs2 + 1; carry = bit DATA_W (1 = no borrow).
  - MOV: rs1; carry=0.
  - LDI: imm; carry=0. The captured operands are ignored.
- WRITE:
  - mode=1, WriteAddress=rd, WriteValue=result for exactly one cycle; the register file commits at that cycle's closing edge.
  - done=1 in this cycle; result and carry outputs update at the same edge.
  - Next state is IDLE.
- Latency and throughput:
  - Handshake at edge T; READ in cycle T+1; EXEC in T+2; WRITE and done in T+3.
  - Next accept is possible at the edge ending T+4, giving 1 command per 4 cycles.
- Mode and bus rules:
  - mode is 0 in every state except WRITE.
  - ReadAddress1/2 hold their last values outside READ.
  - WriteAddress and WriteValue hold their last values outside WRITE.
- Arithmetic: wraps modulo 2**DATA_W; no overflow flag.
- rd equal to rs1 or rs2 is legal; operands were already captured in READ, so the old value is used.
- Register 0 is an ordinary writable register (unless the optional feature is compiled in).
- Reset mid-operation: the FSM returns to IDLE immediately and mode drops to 0 asynchronously. An in-flight command is discarded with no write and no done. result and carry reset to 0.
- cmd_valid held high across a busy period: the command is not accepted until the sequencer returns to IDLE, then it is accepted once.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- Defined:
  - Register 0 reads as zero: an operand whose address is 0 is forced to 0 in READ, regardless of ReadValue.
  - Commands with rd=0 execute and update carry, but mode stays 0 in WRITE (no write). done still pulses and result updates.
- Undefined: register 0 behaves like any other register.

Test Plan:
- Reset: assert rst_n=0 mid-SUB during EXEC -> mode=0 immediately, no done; after release cmd_ready=1, result=0, carry=0, state IDLE.
- LDI sequence: LDI r0=0x1232, then LDI r1=0x1263 -> each write at handshake+3 cycles with mode=1 for exactly one cycle; WriteAddress 0 then 1; done pulses twice.
- ADD: r0=0x1232, r1=0x1263, ADD r2=r0+r1 -> WriteValue=0x2495 to address 2, carry=0, done at handshake+3.
- Carry and SUB: r3=0xFFFF, r4=0x0001.
  - ADD r5=r3+r4 -> result 0x0000, carry=1.
  - SUB r6=r4-r3 -> result 0x0002, carry=0.
  - SUB r7=r3-r4 -> result 0xFFFE, carry=1.
- Back-pressure: cmd_valid held high for 10 cycles with a fixed MOV r8=r1 -> cmd_ready low for 3 cycles after each accept; exactly one write per accepted handshake; r8=0x1263.
- REGFILE_ZERO_REG_EN build: LDI r0=0xABCD -> no write (mode stays 0), done pulses, result=0xABCD; then ADD r9=r0+r1 with r1=0x1263 -> r9=0x1263.
